zout_collect: RTL and testbench

Receiving end of the PSU output-store interface. It consumes the per-cycle store beats (`psu_store_en`, `tapu_store_idx`, `psu_store_data`) that the output controller emits without backpressure. It buffers the beats in an internal FIFO and re-emits them as an AXI-Stream toward the kernel writeback path, with the TAPU index in `m_axis_tuser` and `tlast` on the final word of the tile. It also checks beat count and TAPU-index sequencing and reports completion and sticky errors.

---
 rtl/zout_collect.sv | 159 +++++++++++++++
 tb/tb_zout_collect.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zout_collect.sv
// zout_collect: receiving end of the PSU output-store interface.
// Buffers per-cycle store beats (no backpressure) in a FIFO and re-emits them as an
// AXI-Stream with the TAPU index on tuser and tlast on the final word of the tile.
// Checks beat count and TAPU-index sequencing; reports completion and sticky errors.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   collect_start                 one-cycle pulse arming one tile (ignored while busy)
//   store_depth, store_tapu_depth tile words - 1, words per TAPU - 1 (sampled on start)
//   psu_store_en/_idx/_data       store beat from the output controller
//   m_axis_*                      AXI-Stream output, tuser = TAPU index
//   busy, collect_done            status; done pulses one cycle after the last handshake
//   overflow_err, seq_err, stray_err  sticky error flags, cleared by an accepted start
module zout_collect #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              collect_start,
  input  logic [6:0]        store_depth,
  input  logic [3:0]        store_tapu_depth,
  input  logic              psu_store_en,
  input  logic [2:0]        tapu_store_idx,
  input  logic [DATA_W-1:0] psu_store_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [2:0]        m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              collect_done,
  output logic              overflow_err,
  output logic              seq_err,
  output logic              stray_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_W + 3;

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e      r_state;
  logic [6:0]  r_depth, r_in_cnt, r_out_cnt;
  logic [3:0]  r_tdepth, r_tapu_cnt;
  logic [2:0]  r_exp_idx;
  logic        r_first, r_done, r_ovf, r_seq, r_stray;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] r_wptr, r_rptr;
  logic [EW-1:0] r_mem [FIFO_DEPTH];

  logic          w_empty, w_full, w_pop, w_beat, w_push, w_tapu_wrap;
  logic [EW-1:0] w_head;

  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop       = !w_empty && m_axis_tready;
  assign w_beat      = (r_state == StCollect) && psu_store_en;
  // A pop in the same cycle frees the slot, so a beat on full is still taken.
  assign w_push      = w_beat && (!w_full || w_pop);
  assign w_tapu_wrap = (r_tapu_cnt == r_tdepth);
  assign w_head      = r_mem[r_rptr[AW-1:0]];

  // Head is gated so the data outputs read zero whenever nothing is valid.
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign m_axis_tuser  = w_empty ? '0 : w_head[EW-1 -: 3];
  assign m_axis_tlast  = !w_empty && (r_out_cnt == r_depth);
  assign busy          = (r_state != StIdle);
  assign collect_done  = r_done;
  assign overflow_err  = r_ovf;
  assign seq_err       = r_seq;
  assign stray_err     = r_stray;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {tapu_store_idx, psu_store_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_depth    <= '0;
      r_tdepth   <= '0;
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_tapu_cnt <= '0;
      r_exp_idx  <= '0;
      r_first    <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_seq      <= 1'b0;
      r_stray    <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + (AW+1)'(1);
        r_out_cnt <= r_out_cnt + 7'd1;
      end
      if (psu_store_en && (r_state != StCollect)) begin
        r_stray <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          if (collect_start) begin
            r_state    <= StCollect;
            r_depth    <= store_depth;
            r_tdepth   <= store_tapu_depth;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_tapu_cnt <= '0;
            r_ovf      <= 1'b0;
            r_seq      <= 1'b0;
            // A beat coinciding with the start pulse is still stray.
            r_stray    <= psu_store_en;
            r_first    <= 1'b1;
          end
        end
        StCollect: begin
          if (psu_store_en) begin
            r_in_cnt   <= r_in_cnt + 7'd1;
            r_tapu_cnt <= w_tapu_wrap ? 4'd0 : r_tapu_cnt + 4'd1;
            if (r_first) begin
              // Producer index is free-running across tiles: adopt it, no check.
              r_first   <= 1'b0;
              r_exp_idx <= tapu_store_idx + {2'b00, w_tapu_wrap};
            end else begin
              if (tapu_store_idx != r_exp_idx) begin
                r_seq <= 1'b1;
              end
              r_exp_idx <= r_exp_idx + {2'b00, w_tapu_wrap};
            end
            if (!w_push) begin
              r_ovf <= 1'b1;
            end
            if (r_in_cnt == r_depth) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (w_pop && (r_out_cnt == r_depth)) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_zout_collect.sv
module tb_zout_collect;
  localparam int unsigned DW = 128;
  localparam int unsigned SW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          collect_start = 1'b0;
  logic [6:0]    store_depth = '0;
  logic [3:0]    store_tapu_depth = '0;
  logic          psu_store_en = 1'b0;
  logic [2:0]    tapu_store_idx = '0;
  logic [DW-1:0] psu_store_data = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [2:0]    m_axis_tuser;
  logic          m_axis_tvalid, m_axis_tlast, busy, collect_done;
  logic          m_axis_tready = 1'b0;
  logic          overflow_err, seq_err, stray_err;

  logic          s_start = 1'b0;
  logic [6:0]    s_depth = '0;
  logic [3:0]    s_tdepth = '0;
  logic          s_en = 1'b0;
  logic [2:0]    s_idx = '0;
  logic [SW-1:0] s_data = '0;
  logic [SW-1:0] s_tdata;
  logic [2:0]    s_tuser;
  logic          s_tvalid, s_tlast, s_busy, s_done, s_ovf, s_seq, s_stray;
  logic          s_tready = 1'b0;

  zout_collect #(.DATA_W(DW), .FIFO_DEPTH(128)) u_dut (
    .clk(clk), .rst_n(rst_n), .collect_start(collect_start), .store_depth(store_depth),
    .store_tapu_depth(store_tapu_depth), .psu_store_en(psu_store_en),
    .tapu_store_idx(tapu_store_idx), .psu_store_data(psu_store_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy),
    .collect_done(collect_done), .overflow_err(overflow_err), .seq_err(seq_err),
    .stray_err(stray_err)
  );

  zout_collect #(.DATA_W(SW), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .collect_start(s_start), .store_depth(s_depth),
    .store_tapu_depth(s_tdepth), .psu_store_en(s_en), .tapu_store_idx(s_idx),
    .psu_store_data(s_data), .m_axis_tdata(s_tdata), .m_axis_tuser(s_tuser),
    .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready), .m_axis_tlast(s_tlast),
    .busy(s_busy), .collect_done(s_done), .overflow_err(s_ovf), .seq_err(s_seq),
    .stray_err(s_stray)
  );

  int n_checks = 0;
  int n_fail = 0;
  int rmode = 0;
  int rcnt = 0;
  int done_cnt = 0;
  // Reference stream: {tuser, tlast, tdata} in the order words must leave.
  logic [DW+3:0] want_q[$];
  logic          prev_stall = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [2:0]    held_user = '0;
  logic          held_last = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, want);
    end
  endtask

  // One clock: sample/score at negedge, then drive tready just after posedge.
  task automatic tick();
    logic [DW+3:0] e;
    @(negedge clk);
    if (!rst_n) begin
      want_q.delete();
      prev_stall = 1'b0;
      prev_last  = 1'b0;
    end else begin
      check_eq("collect_done", DW'(collect_done), DW'(prev_last));
      if (collect_done) done_cnt++;
      if (prev_stall) begin
        check_eq("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
        check_eq("hold_tdata", m_axis_tdata, held_data);
        check_eq("hold_tuser", DW'(m_axis_tuser), DW'(held_user));
        check_eq("hold_tlast", DW'(m_axis_tlast), DW'(held_last));
      end
      prev_last = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (want_q.size() == 0) begin
          check_eq("extra_word", DW'(m_axis_tvalid), DW'(0));
        end else begin
          e = want_q.pop_front();
          check_eq("tdata", m_axis_tdata, e[DW-1:0]);
          check_eq("tuser", DW'(m_axis_tuser), DW'(e[DW+3:DW+1]));
          check_eq("tlast", DW'(m_axis_tlast), DW'(e[DW]));
          prev_last = e[DW];
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held_data  = m_axis_tdata;
      held_user  = m_axis_tuser;
      held_last  = m_axis_tlast;
    end
    @(posedge clk);
    #1;
    rcnt++;
    case (rmode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (rcnt % 3 == 0);
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  // Tile driver; expected index of beat k is start + k/(tdepth+1), mod 8.
  task automatic run_tile(input string name, input int depth, input int tdepth, input int sidx,
                          input int bad_k, input int bad_v, input bit mid_start,
                          input bit start_stray, input bit gaps);
    int            idx;
    int            base;
    bit            want_seq;
    logic [DW-1:0] d;
    base     = done_cnt;
    want_seq = 1'b0;
    collect_start    = 1'b1;
    store_depth      = 7'(depth);
    store_tapu_depth = 4'(tdepth);
    psu_store_en     = start_stray;
    tapu_store_idx   = 3'(sidx + 4);
    psu_store_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
    tick();
    collect_start = 1'b0;
    for (int k = 0; k <= depth; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          psu_store_en = 1'b0;
          tick();
        end
      end
      idx = (sidx + k / (tdepth + 1)) % 8;
      if (k == bad_k) begin
        if (bad_v != idx) want_seq = 1'b1;
        idx = bad_v;
      end
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      psu_store_en   = 1'b1;
      tapu_store_idx = 3'(idx);
      psu_store_data = d;
      collect_start  = mid_start && (k == 1);
      if (mid_start && k == 1) store_depth = 7'd0;
      want_q.push_back({3'(idx), (k == depth), d});
      tick();
    end
    psu_store_en  = 1'b0;
    collect_start = 1'b0;
    for (int c = 0; c < 1500 && done_cnt == base; c++) tick();
    check_eq({name, "_done_count"}, DW'(done_cnt - base), DW'(1));
    check_eq({name, "_busy"}, DW'(busy), DW'(0));
    check_eq({name, "_left"}, DW'(want_q.size()), DW'(0));
    check_eq({name, "_seq_err"}, DW'(seq_err), DW'(want_seq));
    check_eq({name, "_stray_err"}, DW'(stray_err), DW'(start_stray));
    check_eq({name, "_ovf_err"}, DW'(overflow_err), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] sd [8];
    #1;
    check_eq("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    check_eq("rst_tdata", m_axis_tdata, DW'(0));
    check_eq("rst_tuser", DW'(m_axis_tuser), DW'(0));
    check_eq("rst_tlast", DW'(m_axis_tlast), DW'(0));
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_done", DW'(collect_done), DW'(0));
    check_eq("rst_errs", DW'({overflow_err, seq_err, stray_err}), DW'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();

    rmode = 0;
    run_tile("basic", 7, 1, 0, -1, 0, 1'b0, 1'b0, 1'b0);
    run_tile("depth0", 0, 0, 6, -1, 0, 1'b0, 1'b0, 1'b0);
    rmode = 1;
    run_tile("backpressure", 127, 15, 3, -1, 0, 1'b0, 1'b0, 1'b0);
    rmode = 0;
    run_tile("carry", 3, 0, 5, -1, 0, 1'b0, 1'b0, 1'b0);
    run_tile("seq_bad", 3, 0, 5, 2, 3, 1'b0, 1'b0, 1'b0);

    // Stray beat while idle: flagged, nothing emitted.
    psu_store_en = 1'b1;
    tick();
    psu_store_en = 1'b0;
    tick();
    tick();
    check_eq("stray_idle", DW'(stray_err), DW'(1));
    check_eq("stray_no_out", DW'(m_axis_tvalid), DW'(0));
    run_tile("start_stray", 5, 2, 1, -1, 0, 1'b0, 1'b1, 1'b0);
    rmode = 2;
    run_tile("mid_start", 9, 1, 7, -1, 0, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      run_tile("random", $urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 7),
               -1, 0, 1'b0, 1'b0, 1'b1);
    end

    // Overflow on the 4-entry build with the sink stalled.
    s_tready = 1'b0;
    s_start  = 1'b1;
    s_depth  = 7'd7;
    s_tdepth = 4'd0;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sd[k]  = SW'($urandom());
      s_en   = 1'b1;
      s_idx  = 3'(k);
      s_data = sd[k];
      tick();
      if (k == 3) check_eq("ovf_after_4", DW'(s_ovf), DW'(0));
      if (k == 4) check_eq("ovf_after_5", DW'(s_ovf), DW'(1));
    end
    s_en = 1'b0;
    tick();
    check_eq("ovf_busy", DW'(s_busy), DW'(1));
    check_eq("ovf_seq", DW'(s_seq), DW'(0));
    // A beat now is stray only if the tile has moved on to DRAIN.
    s_en = 1'b1;
    tick();
    s_en = 1'b0;
    check_eq("ovf_drain_stray", DW'(s_stray), DW'(1));
    s_tready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check_eq("ovf_tvalid", DW'(s_tvalid), DW'(1));
      check_eq("ovf_tdata", DW'(s_tdata), DW'(sd[j]));
      check_eq("ovf_tuser", DW'(s_tuser), DW'(j));
      check_eq("ovf_tlast", DW'(s_tlast), DW'(0));
      tick();
    end
    tick();
    check_eq("ovf_empty", DW'(s_tvalid), DW'(0));
    check_eq("ovf_stuck_busy", DW'(s_busy), DW'(1));
    check_eq("ovf_no_done", DW'(s_done), DW'(0));

    // Reset mid-tile on the main instance.
    rmode = 3;
    collect_start    = 1'b1;
    store_depth      = 7'd7;
    store_tapu_depth = 4'd0;
    tick();
    collect_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      psu_store_en   = 1'b1;
      tapu_store_idx = 3'(k);
      psu_store_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    psu_store_en = 1'b0;
    check_eq("pre_rst_tvalid", DW'(m_axis_tvalid), DW'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    check_eq("async_rst_busy", DW'(busy), DW'(0));
    check_eq("async_rst_tdata", m_axis_tdata, DW'(0));
    check_eq("async_rst_small", DW'({s_ovf, s_stray, s_busy}), DW'(0));
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    rmode = 2;
    tick();
    run_tile("after_rst", 7, 1, 2, -1, 0, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
